// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: assembles A/B/C/op from a byte stream, holds them for one calc execute cycle, returns R/carry over valid/ready
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort of the current transaction
//   in_valid/in_ready     byte stream handshake, in_data carries A, B, C, op in order
//   calc_a/b/c/op         registered operands driven into the combinational calc core
//   calc_r/calc_cout      calc core result and carry
//   out_valid/out_ready   result handshake, out_result/out_carry hold the captured result
//   busy                  high whenever a transaction is in progress (state other than LD_A)
//   txn_count             completed result handshakes, wraps at 2^CNT_W
module calc_operand_sequencer #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 2,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] calc_a,
   output logic [DATA_W-1:0] calc_b,
   output logic [DATA_W-1:0] calc_c,
   output logic [OP_W-1:0]   calc_op,
   input  logic [DATA_W-1:0] calc_r,
   input  logic              calc_cout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_carry,
   output logic              busy,
   output logic [CNT_W-1:0]  txn_count
);
   typedef enum logic [2:0] {LD_A, LD_B, LD_C, LD_OP, EXEC, HOLD} state_t;
   state_t state, state_nxt;
   logic accept, handshake;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= LD_A;
      else state <= state_nxt;
   always_comb begin
      in_ready  = state inside {LD_A, LD_B, LD_C, LD_OP};
      out_valid = state == HOLD;
      // flush outranks both handshakes: nothing is taken or delivered on that edge
      accept    = in_valid && in_ready && !flush;
      handshake = out_valid && out_ready && !flush;
      state_nxt = state;
      unique case (state)
         LD_A:  state_nxt = accept ? LD_B : LD_A;
         LD_B:  state_nxt = accept ? LD_C : LD_B;
         LD_C:  state_nxt = accept ? LD_OP : LD_C;
         LD_OP: state_nxt = accept ? EXEC : LD_OP;
         EXEC:  state_nxt = HOLD;
         HOLD:  state_nxt = handshake ? LD_A : HOLD;
         default: state_nxt = LD_A;
      endcase
      if (flush) state_nxt = LD_A;
   end
   assign busy = state != LD_A;
   // operands persist after a transaction (and across flush) until overwritten by their own load
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         calc_a  <= '0;
         calc_b  <= '0;
         calc_c  <= '0;
         calc_op <= '0;
      end else if (accept) begin
         if (state == LD_A) calc_a <= in_data;
         if (state == LD_B) calc_b <= in_data;
         if (state == LD_C) calc_c <= in_data;
         if (state == LD_OP) calc_op <= in_data[OP_W-1:0];
      end
   // result is sampled from the combinational core at the edge that closes EXEC
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_result <= '0;
         out_carry  <= 1'b0;
      end else if (state == EXEC && !flush) begin
         out_result <= calc_r;
         out_carry  <= calc_cout;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) txn_count <= '0;
      else if (handshake) txn_count <= txn_count + 1'b1;
endmodule
